// File: rtl/plic_if.sv
// Peripheral bus bundle between the core and the PLIC: a valid/ready request
// with a fixed one-cycle acknowledge.
interface plic_if;
  logic        plic_valid;
  logic [11:0] plic_addr;
  logic [31:0] plic_wdata;
  logic [3:0]  plic_wstrb;
  logic [31:0] plic_rdata;
  logic        plic_ready;

  modport master (
    output plic_valid, plic_addr, plic_wdata, plic_wstrb,
    input  plic_rdata, plic_ready
  );

  modport slave (
    input  plic_valid, plic_addr, plic_wdata, plic_wstrb,
    output plic_rdata, plic_ready
  );
endinterface

// File: rtl/plic.sv
// Platform-level interrupt controller: gateways, priority arbitration, claim/complete
// and a registered meip. Define PLIC_EDGE_EN to add per-source edge triggering (0x300).
module plic #(
  parameter int unsigned SOURCES = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               rst,
  input  logic               clk,
  plic_if.slave              bus,
  input  logic [SOURCES-1:0] irq_src,
  output logic               meip
);

  localparam logic [11:0] ADDR_PEND   = 12'h080;
  localparam logic [11:0] ADDR_ENABLE = 12'h100;
  localparam logic [11:0] ADDR_THRESH = 12'h200;
  localparam logic [11:0] ADDR_CLAIM  = 12'h204;
  localparam logic [11:0] ADDR_EDGE   = 12'h300;

  // Bit i-1 of every per-source vector belongs to source ID i.
  logic [SOURCES-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [SOURCES-1:0]             enable_q, enable_d;
  logic [SOURCES-1:0]             pending_q, pending_d;
  logic [SOURCES-1:0]             inflight_q, inflight_d;
  logic [PRIO_W-1:0]              thresh_q, thresh_d;
  logic                           meip_q, meip_d;
  logic                           ready_q, ready_d;
  logic [31:0]                    rdata_q, rdata_d;

  logic                           accept, is_rd, is_wr, aligned;
  logic [4:0]                     best_id;
  logic [PRIO_W-1:0]              best_prio;
  logic [31:0]                    rd_val;
  logic [SOURCES-1:0]             inflight_n;
  logic [SOURCES-1:0]             pend_set;

`ifdef PLIC_EDGE_EN
  logic [SOURCES-1:0]             edge_q, edge_d;
  logic [SOURCES-1:0]             shadow_q, shadow_d;
  logic [SOURCES-1:0]             irq_prev_q;
  logic [SOURCES-1:0]             rise, busy, trig;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.plic_wdata, bus.plic_addr};

  assign accept  = bus.plic_valid && !ready_q;
  assign is_rd   = (bus.plic_wstrb == 4'b0000);
  assign is_wr   = (bus.plic_wstrb == 4'b1111);
  assign aligned = (bus.plic_addr[1:0] == 2'b00);

  // Strict '>' while scanning upward keeps the lowest ID on a priority tie.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      if (pending_q[i] && enable_q[i] && (prio_q[i] > best_prio)) begin
        best_id   = 5'(i + 1);
        best_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (aligned) begin
      case (bus.plic_addr)
        ADDR_PEND:   rd_val = 32'(pending_q) << 1;
        ADDR_ENABLE: rd_val = 32'(enable_q) << 1;
        ADDR_THRESH: rd_val = 32'(thresh_q);
        ADDR_CLAIM:  rd_val = 32'(best_id);
`ifdef PLIC_EDGE_EN
        ADDR_EDGE:   rd_val = 32'(edge_q) << 1;
`endif
        default: begin
          if (bus.plic_addr[11:7] == 5'd0) begin
            for (int unsigned i = 0; i < SOURCES; i++) begin
              if (bus.plic_addr[6:2] == 5'(i + 1)) rd_val = 32'(prio_q[i]);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    prio_d     = prio_q;
    enable_d   = enable_q;
    thresh_d   = thresh_q;
    inflight_n = inflight_q;
`ifdef PLIC_EDGE_EN
    edge_d     = edge_q;
`endif

    if (accept && is_wr && aligned) begin
      case (bus.plic_addr)
        ADDR_PEND:   ;
        ADDR_ENABLE: enable_d = bus.plic_wdata[SOURCES:1];
        ADDR_THRESH: thresh_d = bus.plic_wdata[PRIO_W-1:0];
        ADDR_CLAIM: begin
          for (int unsigned i = 0; i < SOURCES; i++) begin
            if (bus.plic_wdata[4:0] == 5'(i + 1)) inflight_n[i] = 1'b0;
          end
        end
`ifdef PLIC_EDGE_EN
        ADDR_EDGE:   edge_d = bus.plic_wdata[SOURCES:1];
`endif
        default: begin
          if (bus.plic_addr[11:7] == 5'd0) begin
            for (int unsigned i = 0; i < SOURCES; i++) begin
              if (bus.plic_addr[6:2] == 5'(i + 1)) prio_d[i] = bus.plic_wdata[PRIO_W-1:0];
            end
          end
        end
      endcase
    end
  end

  // Gateways look at in-flight state after this cycle's complete, so a source
  // that is still requesting re-pends on the very next cycle.
`ifdef PLIC_EDGE_EN
  always_comb begin
    rise     = irq_src & ~irq_prev_q;
    busy     = pending_q | inflight_n;
    trig     = (edge_q & rise) | (~edge_q & irq_src) | shadow_q;
    pend_set = trig & ~busy;
    shadow_d = (shadow_q | (edge_q & rise)) & busy;
  end
`else
  assign pend_set = irq_src & ~pending_q & ~inflight_n;
`endif

  always_comb begin
    pending_d  = pending_q | pend_set;
    inflight_d = inflight_n;
    if (accept && is_rd && aligned && (bus.plic_addr == ADDR_CLAIM)) begin
      for (int unsigned i = 0; i < SOURCES; i++) begin
        if (best_id == 5'(i + 1)) begin
          pending_d[i]  = 1'b0;
          inflight_d[i] = 1'b1;
        end
      end
    end
  end

  assign meip_d  = (best_prio > thresh_q);
  assign ready_d = accept;
  assign rdata_d = accept ? rd_val : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q     <= '0;
      enable_q   <= '0;
      pending_q  <= '0;
      inflight_q <= '0;
      thresh_q   <= '0;
      meip_q     <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      prio_q     <= prio_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      thresh_q   <= thresh_d;
      meip_q     <= meip_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef PLIC_EDGE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_q     <= '0;
      shadow_q   <= '0;
      irq_prev_q <= '0;
    end else begin
      edge_q     <= edge_d;
      shadow_q   <= shadow_d;
      irq_prev_q <= irq_src;
    end
  end
`endif

  assign bus.plic_ready = ready_q;
  assign bus.plic_rdata = rdata_q;
  assign meip           = meip_q;

endmodule

// File: tb/tb_plic.sv
// Self-checking bench for plic: register map, gateways, arbitration, claim/complete
// and meip timing; read expectations travel through a scoreboard queue.
`timescale 1ns/1ps
module tb_plic;

  logic       clk;
  logic       rst;
  logic [7:0] irq_src;
  logic       meip;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  plic_if bus_if();

  plic #(.SOURCES(8), .PRIO_W(3)) dut (
    .rst     (rst),
    .clk     (clk),
    .bus     (bus_if),
    .irq_src (irq_src),
    .meip    (meip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus access: ready must come exactly one cycle after valid and last one
  // cycle. Reads pop their expected value from the scoreboard on ready.
  task automatic access(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned n;
    logic [31:0] e;
    string       nm;
    bus_if.plic_valid = 1'b1;
    bus_if.plic_addr  = a;
    bus_if.plic_wdata = d;
    bus_if.plic_wstrb = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.plic_ready && n < 8);
    checks++;
    if (!bus_if.plic_ready || n != 1) begin
      errors++;
      $display("FAIL bus_latency addr=%h: ready after %0d cycles, required 1", a, n);
    end
    if (s == 4'b0000 && exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (bus_if.plic_rdata !== e) begin
        errors++;
        $display("FAIL %s: rdata=%h required %h", nm, bus_if.plic_rdata, e);
      end
    end
    bus_if.plic_valid = 1'b0;
    bus_if.plic_wstrb = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus_if.plic_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_pulse addr=%h: ready=%b required 0", a, bus_if.plic_ready);
    end
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    access(a, 32'h0, 4'b0000);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    access(a, d, 4'b1111);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    irq_src = '0;
    bus_if.plic_valid = 1'b0;
    bus_if.plic_addr  = '0;
    bus_if.plic_wdata = '0;
    bus_if.plic_wstrb = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (meip !== 1'b0 || bus_if.plic_ready !== 1'b0 || bus_if.plic_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: meip=%b ready=%b rdata=%h required 0/0/0",
               meip, bus_if.plic_ready, bus_if.plic_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    rd(12'h080, 32'h0, "reset_pending");
    rd(12'h100, 32'h0, "reset_enable");
    rd(12'h200, 32'h0, "reset_thresh");
    rd(12'h204, 32'h0, "reset_claim");
    checks++;
    if (meip !== 1'b0) begin
      errors++;
      $display("FAIL reset_meip: meip=%b required 0", meip);
    end
  endtask

  task automatic test_single_source;
    wr(12'h00C, 32'd2);
    wr(12'h100, 32'h08);
    wr(12'h200, 32'd0);
    irq_src[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (meip !== 1'b0) begin
      errors++;
      $display("FAIL meip_n1: meip=%b required 0", meip);
    end
    @(negedge clk);
    checks++;
    if (meip !== 1'b1) begin
      errors++;
      $display("FAIL meip_n2: meip=%b required 1", meip);
    end
    rd(12'h204, 32'd3, "claim3");
    checks++;
    if (meip !== 1'b0) begin
      errors++;
      $display("FAIL meip_after_claim: meip=%b required 0", meip);
    end
    repeat (4) @(negedge clk);
    rd(12'h080, 32'h0, "no_repend_inflight");
    wr(12'h204, 32'd3);
    checks++;
    if (meip !== 1'b1) begin
      errors++;
      $display("FAIL meip_after_complete: meip=%b required 1", meip);
    end
    rd(12'h080, 32'h08, "repend_after_complete");
    irq_src[2] = 1'b0;
    rd(12'h204, 32'd3, "claim3_again");
    wr(12'h204, 32'd3);
    rd(12'h080, 32'h0, "pending_clear");
  endtask

  task automatic test_priority;
    wr(12'h004, 32'd5);
    wr(12'h008, 32'd5);
    wr(12'h010, 32'd7);
    wr(12'h100, 32'h16);
    irq_src = 8'b0000_1011;
    @(negedge clk);
    irq_src = '0;
    @(negedge clk);
    rd(12'h080, 32'h16, "pending_three");
    rd(12'h204, 32'd4, "claim_prio7");
    wr(12'h204, 32'd4);
    rd(12'h204, 32'd1, "claim_tie_low_id");
    wr(12'h204, 32'd1);
    rd(12'h204, 32'd2, "claim_last");
    wr(12'h204, 32'd2);
    rd(12'h204, 32'd0, "claim_none");
  endtask

  task automatic test_threshold;
    wr(12'h014, 32'd3);
    wr(12'h200, 32'd3);
    wr(12'h100, 32'h20);
    irq_src[4] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (meip !== 1'b0) begin
      errors++;
      $display("FAIL meip_masked_thresh: meip=%b required 0", meip);
    end
    irq_src[4] = 1'b0;
    rd(12'h204, 32'd5, "claim_ignores_thresh");
    wr(12'h204, 32'd5);
    wr(12'h200, 32'd2);
    irq_src[4] = 1'b1;
    @(negedge clk);
    irq_src[4] = 1'b0;
    @(negedge clk);
    checks++;
    if (meip !== 1'b1) begin
      errors++;
      $display("FAIL meip_thresh_lowered: meip=%b required 1", meip);
    end
    rd(12'h204, 32'd5, "claim5");
    wr(12'h204, 32'd5);
  endtask

  task automatic test_ignored_writes;
    irq_src[4] = 1'b1;
    repeat (2) @(negedge clk);
    rd(12'h204, 32'd5, "claim5_hold");
    wr(12'h204, 32'd6);
    wr(12'h204, 32'd0);
    rd(12'h080, 32'h0, "bad_complete_no_effect");
    wr(12'h204, 32'd5);
    rd(12'h080, 32'h20, "good_complete_repends");
    irq_src[4] = 1'b0;
    rd(12'h204, 32'd5, "claim5_final");
    wr(12'h204, 32'd5);
    access(12'h100, 32'hFFFF_FFFF, 4'b0011);
    rd(12'h100, 32'h20, "partial_strobe_ignored");
    wr(12'h004, 32'hFF);
    rd(12'h004, 32'd7, "prio_upper_bits");
    rd(12'h014, 32'd3, "prio5_readback");
    rd(12'h000, 32'h0, "prio0_zero");
    rd(12'h400, 32'h0, "unmapped_zero");
  endtask

  task automatic test_edge;
`ifdef PLIC_EDGE_EN
    wr(12'h300, 32'h04);
    rd(12'h300, 32'h04, "edge_readback");
    wr(12'h008, 32'd1);
    wr(12'h100, 32'h04);
    irq_src[1] = 1'b1;
    @(negedge clk);
    irq_src[1] = 1'b0;
    @(negedge clk);
    rd(12'h080, 32'h04, "edge_pending");
    rd(12'h204, 32'd2, "edge_claim");
    irq_src[1] = 1'b1;
    @(negedge clk);
    irq_src[1] = 1'b0;
    @(negedge clk);
    rd(12'h080, 32'h0, "edge_shadow_held");
    wr(12'h204, 32'd2);
    rd(12'h080, 32'h04, "edge_repend_after_complete");
    rd(12'h204, 32'd2, "edge_claim_again");
    wr(12'h204, 32'd2);
    rd(12'h080, 32'h0, "edge_idle");
`else
    wr(12'h300, 32'hFF);
    rd(12'h300, 32'h0, "edge_reg_absent");
`endif
  endtask

  task automatic test_reset_mid_access;
    bus_if.plic_valid = 1'b1;
    bus_if.plic_addr  = 12'h100;
    bus_if.plic_wstrb = 4'b0000;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.plic_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_access: ready=%b required 0", bus_if.plic_ready);
    end
    bus_if.plic_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd(12'h100, 32'h0, "enable_after_reset");
  endtask

  initial begin
    test_reset;
    test_single_source;
    test_priority;
    test_threshold;
    test_ignored_writes;
    test_edge;
    test_reset_mid_access;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
